riscv_register_file: RTL and testbench
======================================

Name: riscv_register_file

Overview:
- 32-entry x 32-bit integer register file (x0..x31) for the single-cycle RISC-V core.
- Sits directly downstream of the write-back path, which produces the rd value, and upstream of the ALU operand muxes.
- Built from the same Tick/ClockEnable-gated storage style as the core's register primitives, with two combinational read ports and one synchronous write port.
- Also provides a debug read port and a write-conflict flag.

Parameters:
NrOfBits, 32, data width of each register
NrOfRegs, 32, number of architectural registers; must be a power of two
AddrBits, 5, address width, equal to log2(NrOfRegs)
Bypass, 1, when 1, a read of the register being written this cycle returns the write data

Ports:
Clock  input  1  single system clock; all state updates on its rising edge
Reset  input  1  synchronous, active-high; clears every register on the next rising edge of Clock
ClockEnable  input  1  global enable; a write requires ClockEnable & Tick
Tick  input  1  clock-divider tick, same meaning as on the core's other registers
rs1_addr  input  AddrBits  read port 1 address
rs2_addr  input  AddrBits  read port 2 address
rs1_data  output  NrOfBits  read port 1 data, combinational
rs2_data  output  NrOfBits  read port 2 data, combinational
we  input  1  write enable from control
rd_addr  input  AddrBits  write address
rd_data  input  NrOfBits  write data from write-back mux
dbg_addr  input  AddrBits  debug read address
dbg_req  input  1  debug read request, one-cycle pulse
dbg_data  output  NrOfBits  registered debug read data
dbg_valid  output  1  one-cycle pulse when dbg_data is updated
wr_count  output  16  number of committed writes since reset, wraps

Behaviour:
- Reset (synchronous, active-high):
  - All registers become 0 on the next rising edge of Clock.
  - dbg_data=0, dbg_valid=0, wr_count=0.
  - Reset has priority over write and debug in the same cycle; a write presented during Reset is dropped.
- Commit condition: commit = we & ClockEnable & Tick & ~Reset & (rd_addr != 0).
  - When commit is true at a rising edge, reg[rd_addr] <= rd_data.
  - No other register changes.
- x0 is hardwired to zero:
  - Writes to address 0 are discarded and do not increment wr_count.
  - Reads of address 0 always return 0, including under bypass.
- Read ports, zero latency:
  - rsN_data = 0 if rsN_addr == 0.
  - Else, if Bypass==1 and commit and rd_addr == rsN_addr, rsN_data = rd_data.
  - Else rsN_data = reg[rsN_addr].
- With Bypass==0, a read of the register being written returns the old value until after the edge.
- rs1 and rs2 addressing the same register both return the same value; the two ports are independent.
- Debug port:
  - On a rising edge with dbg_req=1 (and no Reset), dbg_data <= the value at dbg_addr as it stands after that edge's write. This means a same-edge write to dbg_addr is reflected in dbg_data.
  - dbg_valid is 1 in the following cycle only.
  - Back-to-back dbg_req in consecutive cycles gives a dbg_valid in each following cycle.
  - dbg_data holds its value when dbg_req=0.
- wr_count increments by 1 on every commit and wraps 0xFFFF -> 0x0000.
- ClockEnable=0 or Tick=0 blocks writes.
  - The debug port and reads still operate.
  - wr_count does not change.
- Width rules: all addresses are unsigned and no sign extension is performed. AddrBits must equal log2(NrOfRegs); out-of-range addresses cannot occur.

Test Plan:
- Reset: write x5=0x12345678, then assert Reset for one cycle, then read x5 -> 0x00000000; wr_count=0, dbg_valid=0.
- x0: we=1, rd_addr=0, rd_data=0xFFFFFFFF, tick every cycle -> rs1_addr=0 reads 0 both during and after the write; wr_count unchanged.
- Write/read and bypass: x7=0xDEADBEEF committed; next cycle rs1_addr=rs2_addr=7 -> both 0xDEADBEEF. With Bypass=1, a same-cycle write of 0xCAFEF00D to x7 makes rs1_data=0xCAFEF00D before the edge; with Bypass=0 it shows 0xDEADBEEF until the edge.
- Gating: we=1, ClockEnable=1, Tick=0, rd_addr=3, rd_data=0xA5A5A5A5 -> x3 unchanged and wr_count unchanged; raise Tick for one cycle -> x3=0xA5A5A5A5 and wr_count increments by 1.
- Debug: dbg_req pulse with dbg_addr=7 on the same edge that writes x7=0x11 -> next cycle dbg_valid=1 and dbg_data=0x11; the cycle after that, dbg_valid=0 and dbg_data still 0x11.
- Counter wrap: preload wr_count to 0xFFFF via 65535 commits, then one more commit -> wr_count=0x0000. A Reset asserted together with a write -> no register change and wr_count=0.

Source files
------------

// File: rtl/riscv_register_file.sv
// 32 x 32 integer register file: two combinational read ports with optional
// write bypass, one Tick/ClockEnable-gated write port, registered debug read.
module riscv_register_file #(
   parameter int unsigned NrOfBits = 32,
   parameter int unsigned NrOfRegs = 32,
   parameter int unsigned AddrBits = 5,
   parameter bit          Bypass   = 1'b1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                ClockEnable,
   input  logic                Tick,
   input  logic [AddrBits-1:0] rs1_addr,
   input  logic [AddrBits-1:0] rs2_addr,
   output logic [NrOfBits-1:0] rs1_data,
   output logic [NrOfBits-1:0] rs2_data,
   input  logic                we,
   input  logic [AddrBits-1:0] rd_addr,
   input  logic [NrOfBits-1:0] rd_data,
   input  logic [AddrBits-1:0] dbg_addr,
   input  logic                dbg_req,
   output logic [NrOfBits-1:0] dbg_data,
   output logic                dbg_valid,
   output logic [15:0]         wr_count
);

   logic [NrOfBits-1:0] regs [NrOfRegs];
   logic                commit;

   assign commit = we & ClockEnable & Tick & ~Reset & (rd_addr != '0);

   // x0 reads as zero regardless of storage contents; fwd selects the
   // in-flight write value, which is also the post-edge value of that entry.
   function automatic logic [NrOfBits-1:0] read_port(input logic [AddrBits-1:0] addr,
                                                      input logic                fwd);
      if (addr == '0)
         return '0;
      else if (fwd && commit && (rd_addr == addr))
         return rd_data;
      else
         return regs[addr];
   endfunction

   assign rs1_data = read_port(rs1_addr, Bypass);
   assign rs2_data = read_port(rs2_addr, Bypass);

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < NrOfRegs; i++)
            regs[i] <= '0;
      end else if (commit) begin
         regs[rd_addr] <= rd_data;
      end
   end

   // Debug snapshot always forwards so a same-edge write to dbg_addr is seen.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         dbg_data  <= '0;
         dbg_valid <= 1'b0;
      end else begin
         dbg_valid <= dbg_req;
         if (dbg_req)
            dbg_data <= read_port(dbg_addr, 1'b1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset)
         wr_count <= '0;
      else if (commit)
         wr_count <= wr_count + 16'd1;
   end

endmodule

// File: tb/tb_riscv_register_file.sv
// Randomized + directed bench for riscv_register_file; one instance with
// bypass, one without, both checked against an array-based reference model.
module tb_riscv_register_file;

   logic        clk = 1'b0;
   logic        rst, ce, tick, we, dbgr;
   logic [4:0]  rs1a, rs2a, rda, dbga;
   logic [31:0] rdd;

   logic [31:0] rs1_b1, rs2_b1, dbgd_b1, rs1_b0, rs2_b0, dbgd_b0;
   logic        dbgv_b1, dbgv_b0;
   logic [15:0] cnt_b1, cnt_b0;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [31:0] model [32];
   logic [31:0] m_dbgd;
   logic        m_dbgv;
   logic [15:0] m_cnt;
   bit          chk_reads;

   always #5 clk = ~clk;

   riscv_register_file #(.NrOfBits(32), .NrOfRegs(32), .AddrBits(5), .Bypass(1'b1)) dut_b1 (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick),
      .rs1_addr(rs1a), .rs2_addr(rs2a), .rs1_data(rs1_b1), .rs2_data(rs2_b1),
      .we(we), .rd_addr(rda), .rd_data(rdd),
      .dbg_addr(dbga), .dbg_req(dbgr), .dbg_data(dbgd_b1), .dbg_valid(dbgv_b1),
      .wr_count(cnt_b1));

   riscv_register_file #(.NrOfBits(32), .NrOfRegs(32), .AddrBits(5), .Bypass(1'b0)) dut_b0 (
      .Clock(clk), .Reset(rst), .ClockEnable(ce), .Tick(tick),
      .rs1_addr(rs1a), .rs2_addr(rs2a), .rs1_data(rs1_b0), .rs2_data(rs2_b0),
      .we(we), .rd_addr(rda), .rd_data(rdd),
      .dbg_addr(dbga), .dbg_req(dbgr), .dbg_data(dbgd_b0), .dbg_valid(dbgv_b0),
      .wr_count(cnt_b0));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit will_commit();
      return we && ce && tick && !rst && (rda != 5'd0);
   endfunction

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'h0;
      if (byp && will_commit() && rda == a) return rdd;
      return model[a];
   endfunction

   task automatic idle();
      rst = 0; ce = 1; tick = 1; we = 0; dbgr = 0;
      rs1a = 0; rs2a = 0; rda = 0; dbga = 0; rdd = 0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      we = 1; rda = a; rdd = d;
   endtask

   // Inputs are set by the caller; reads checked mid-cycle, then the model
   // advances at the edge and registered outputs are checked just after it.
   task automatic cycle();
      #2;
      if (chk_reads) begin
         check("rs1_byp",   rs1_b1, exp_read(rs1a, 1'b1));
         check("rs2_byp",   rs2_b1, exp_read(rs2a, 1'b1));
         check("rs1_nobyp", rs1_b0, exp_read(rs1a, 1'b0));
         check("rs2_nobyp", rs2_b0, exp_read(rs2a, 1'b0));
      end
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         m_cnt = 0; m_dbgv = 0; m_dbgd = 0;
      end else begin
         if (will_commit()) begin
            model[rda] = rdd;
            m_cnt = m_cnt + 16'd1;
         end
         m_dbgv = dbgr;
         if (dbgr) m_dbgd = model[dbga];
      end
      #1;
      check("dbg_valid", {31'b0, dbgv_b1}, {31'b0, m_dbgv});
      check("dbg_data",  dbgd_b1, m_dbgd);
      check("wr_count",  {16'b0, cnt_b1}, {16'b0, m_cnt});
      check("dbg_valid0", {31'b0, dbgv_b0}, {31'b0, m_dbgv});
      check("dbg_data0",  dbgd_b0, m_dbgd);
      check("wr_count0",  {16'b0, cnt_b0}, {16'b0, m_cnt});
      idle();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      m_cnt = 0; m_dbgv = 0; m_dbgd = 0;
      idle();
      chk_reads = 0;
      rst = 1; cycle();
      chk_reads = 1;

      // Reset clears x5; a write presented together with Reset is dropped
      write(5'd5, 32'h12345678); cycle();
      rs1a = 5; cycle();
      rst = 1; write(5'd9, 32'h99999999); cycle();
      rs1a = 5; rs2a = 9; cycle();
      check("x5_after_reset", rs1_b1, 32'h0);
      check("cnt_after_reset", {16'b0, cnt_b1}, 32'h0);

      // x0 hardwired
      write(5'd0, 32'hFFFFFFFF); rs1a = 0; cycle();
      write(5'd0, 32'hFFFFFFFF); rs1a = 0; cycle();
      rs1a = 0; cycle();

      // write/read and bypass vs. no bypass
      write(5'd7, 32'hDEADBEEF); cycle();
      rs1a = 7; rs2a = 7; write(5'd7, 32'hCAFEF00D); cycle();
      rs1a = 7; rs2a = 7; cycle();

      // Tick gating
      tick = 0; write(5'd3, 32'hA5A5A5A5); rs1a = 3; cycle();
      ce = 0;   write(5'd3, 32'hA5A5A5A5); rs1a = 3; cycle();
      write(5'd3, 32'hA5A5A5A5); cycle();
      rs1a = 3; cycle();

      // debug read concurrent with a write to the same register, then hold
      write(5'd7, 32'h11); dbgr = 1; dbga = 7; cycle();
      check("dbg_same_edge", dbgd_b1, 32'h11);
      cycle();
      dbgr = 1; dbga = 3; cycle();
      dbgr = 1; dbga = 0; cycle();
      cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 99) == 0);
         ce   = ($urandom_range(0, 3) != 0);
         tick = ($urandom_range(0, 3) != 0);
         we   = $urandom_range(0, 1);
         rda  = 5'($urandom);
         rdd  = $urandom;
         rs1a = ($urandom_range(0, 3) == 0) ? rda : 5'($urandom);
         rs2a = ($urandom_range(0, 3) == 0) ? rs1a : 5'($urandom);
         dbgr = $urandom_range(0, 1);
         dbga = ($urandom_range(0, 2) == 0) ? rda : 5'($urandom);
         cycle();
      end

      // wr_count wrap
      rst = 1; cycle();
      for (int n = 0; n < 65535; n++) begin
         write(5'(1 + $urandom_range(0, 30)), $urandom);
         rs1a = 5'($urandom);
         cycle();
      end
      check("wrap_ffff", {16'b0, cnt_b1}, 32'h0000FFFF);
      write(5'd1, 32'h1); cycle();
      check("wrap_zero", {16'b0, cnt_b1}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
